// File: rtl/montgomery_pkg.sv
// Shared FSM state encoding and operating-mode constants for the iterative
// Montgomery multiplier.
package montgomery_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic MODE_PLAIN = 1'b0;
  localparam logic MODE_MONT  = 1'b1;

endpackage

// File: rtl/montgomery_step.sv
// One radix-2 Montgomery iteration: S = (S + a_i*b [+ N]) / 2.
// Purely combinational; the W+2-bit width holds S + b + N without wrap.
module montgomery_step #(
  parameter int W = 12,
  parameter int N = 3329
) (
  input  logic [W+1:0] s_in,
  input  logic         a_bit,
  input  logic [W-1:0] b,
  output logic [W+1:0] s_out
);

  localparam logic [W+1:0] N_S = (W+2)'(N);

  logic [W+1:0] add_b;
  logic [W+1:0] sum;

  always_comb begin
    add_b = s_in + (a_bit ? {2'b00, b} : '0);
    // Adding the odd modulus makes an odd sum even so the halving is exact.
    sum   = add_b + (add_b[0] ? N_S : '0);
    s_out = {1'b0, sum[W+1:1]};
  end

endmodule

// File: rtl/montgomery_mul_iter.sv
// Bit-serial modular multiplier: Montgomery product in W+2 cycles, plain a*b mod N in 2W+3
// (second pass multiplies by R^2 mod N); result held in DONE until out_ready, one request in flight.
module montgomery_mul_iter
  import montgomery_pkg::*;
#(
  parameter int W        = 12,
  parameter int N        = 3329,
  parameter int R2_MOD_N = 2385
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         out_err,
  output logic         busy
);

  localparam int             CW       = $clog2(W + 1);
  localparam logic [W+1:0]   N_S      = (W+2)'(N);
  localparam logic [W-1:0]   N_W      = W'(N);
  localparam logic [W-1:0]   R2_W     = W'(R2_MOD_N);
  localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);

  state_t        state_q, state_d;
  logic [W+1:0]  s_q, s_d;
  logic [W-1:0]  mult_q, mult_d;
  logic [W-1:0]  mcand_q, mcand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic          err_q, err_d;
  logic          pass2_q, pass2_d;
  logic [W-1:0]  result_q, result_d;

  logic [W+1:0]  step_out;
  logic [W+1:0]  s_red;
  logic          accept;

  montgomery_step #(.W(W), .N(N)) u_step (
    .s_in  (s_q),
    .a_bit (mult_q[0]),
    .b     (mcand_q),
    .s_out (step_out)
  );

  assign s_red     = (s_q >= N_S) ? (s_q - N_S) : s_q;
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign out_err   = out_valid && err_q;
  assign result    = result_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    mult_d   = mult_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    err_d    = err_q;
    pass2_d  = pass2_q;
    result_d = result_q;

    case (state_q)
      IDLE: ;
      ITER: begin
        s_d    = step_out;
        mult_d = mult_q >> 1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = FINAL;
      end
      FINAL: begin
        s_d = s_red;
        // Plain mode converts out of the Montgomery domain with a second pass by R^2.
        if ((mode_q == MODE_PLAIN) && !pass2_q) begin
          pass2_d = 1'b1;
          mult_d  = s_red[W-1:0];
          mcand_d = R2_W;
          s_d     = '0;
          cnt_d   = '0;
          state_d = ITER;
        end else begin
          result_d = err_q ? '0 : s_red[W-1:0];
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
    endcase

    if (accept) begin
      s_d     = '0;
      cnt_d   = '0;
      mult_d  = a;
      mcand_d = b;
      mode_d  = mode;
      err_d   = (a >= N_W) || (b >= N_W);
      pass2_d = 1'b0;
      state_d = ITER;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      s_q      <= '0;
      mult_q   <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      mode_q   <= MODE_PLAIN;
      err_q    <= 1'b0;
      pass2_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      mult_q   <= mult_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      err_q    <= err_d;
      pass2_q  <= pass2_d;
      result_q <= result_d;
    end
  end

endmodule
